servo_pwm: RTL and testbench
============================

SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000000, sets the clk cycles per PWM frame (20 ms at 50 MHz).
REQ-002 Parameter MIN_CYCLES, default 50000, sets the pulse width for position 0 (1 ms).
REQ-003 Parameter STEP_CYCLES, default 196, sets the extra pulse cycles per position LSB.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high (ports clk, rst).
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 sclk  input  1  slow step clock from the frequency divider, a level signal asynchronous in phase to clk.
REQ-008 pos_valid  input  1  a new target position is offered.
REQ-009 pos_data  input  8  target position, 0..255.
REQ-010 pos_ready  output  1  the block can accept pos_data.
REQ-011 pwm_out  output  1  servo PWM signal.
REQ-012 frame_start  output  1  one-cycle pulse on the first cycle of each frame.
REQ-013 busy  output  1  high while cur_pos differs from target.

Function
REQ-014 The sclk input SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL produce a one-cycle step_tick, with 3 clk cycles of latency from the sclk edge.
REQ-015 A transfer SHALL occur when pos_valid && pos_ready are high on the same clk edge; pos_data goes into a one-entry pending register and pending_full is set.
REQ-016 pos_ready SHALL equal !pending_full, registered; the block accepts no new value while pending_full is set.
REQ-017 On frame_start, if pending_full is set, pending SHALL move to target and pending_full SHALL clear; pos_ready rises on the following cycle.
REQ-018 On each step_tick, cur_pos SHALL move 1 toward target; when cur_pos equals target it holds; cur_pos never overshoots.
REQ-019 If step_tick and a target update coincide, the step SHALL use the pre-update target value.
REQ-020 frame_cnt SHALL count 0..FRAME_CYCLES-1 and wrap to 0; frame_start SHALL be high when frame_cnt==0.
REQ-021 On frame_start, width SHALL latch MIN_CYCLES + cur_pos*STEP_CYCLES.
  - Computed at a width sufficient for the parameter values, with no truncation.
  - Used for the whole frame, so the output is glitch-free.
REQ-022 FSM states:
  - PULSE: pwm_out=1; moves to GAP when frame_cnt==width-1.
  - GAP: pwm_out=0; moves to PULSE on frame wrap.
REQ-023 pwm_out SHALL be a registered output; its high time SHALL be exactly width cycles per frame.
REQ-024 busy SHALL be registered and equal (cur_pos != target).
REQ-025 Parameters SHALL satisfy MIN_CYCLES + 255*STEP_CYCLES < FRAME_CYCLES; the width never reaches the full frame.

Reset
REQ-026 While rst is high, the following SHALL hold:
  - Outputs: pwm_out=0, frame_start=0, busy=0, pos_ready=0.
  - State: frame_cnt=0, FSM=PULSE, cur_pos=target=128, pending_full=0, synchronizer flops=0, width=MIN_CYCLES+128*STEP_CYCLES.
REQ-027 On the first cycle after rst deasserts, frame_start=1 and pos_ready=1.
REQ-028 A reset asserted mid-pulse SHALL drop pwm_out on the next edge and discard any pending value.

Structure
REQ-029 Shared package servo_pkg SHALL hold POS_W=8, POS_CENTER=8'd128 and the FSM state typedef.
REQ-030 Sub-module edge_sync SHALL implement the synchronizer and rising-edge detect of REQ-014.
REQ-031 The rest of the block SHALL live in the top level.

Verification (bench params FRAME_CYCLES=1000, MIN_CYCLES=50, STEP_CYCLES=2)
REQ-032 Reset, then idle for 3 frames.
  - pwm_out high 306 cycles per 1000-cycle frame.
  - frame_start period 1000; busy=0.
REQ-033 Write 200 mid-frame with no sclk edges.
  - pos_ready=0 until the next frame_start+1.
  - target=200, busy=1, width stays 306.
REQ-034 Write 200, then give 72 sclk edges.
  - cur_pos reaches 200 and busy falls.
  - The next frame has pwm_out high 450 cycles; further edges leave cur_pos at 200.
REQ-035 Write 0 and 255 back-to-back with pos_valid held.
  - The second value is accepted only after frame_start clears pending.
  - Final target=255.
REQ-036 Assert rst at frame_cnt=100 during PULSE.
  - pwm_out=0 next cycle, pending cleared.
  - After release, cur_pos=128 and the frame restarts.
REQ-037 Make an sclk edge coincide with frame_start pending transfer (cur_pos=target=50, pending=10).
  - cur_pos stays 50 that cycle, then steps down on later ticks.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and FSM state encoding for the servo PWM block.
package servo_pkg;

  localparam int unsigned POS_W = 8;
  localparam logic [POS_W-1:0] POS_CENTER = 8'd128;

  typedef enum logic {
    PULSE = 1'b0,
    GAP   = 1'b1
  } state_t;

endpackage

// File: rtl/servo_pwm_edge_sync.sv
// Two-flop synchronizer for the slow step clock plus a registered rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  output logic step_tick
);

  logic s1;
  logic s2;
  logic s2_d;

  // Tick appears on the third clk edge after sclk rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s2_d      <= 1'b0;
      step_tick <= 1'b0;
    end else begin
      s1        <= sclk;
      s2        <= s1;
      s2_d      <= s2;
      step_tick <= s2 & ~s2_d;
    end
  end

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM generator: position handshake, slew-limited position, frame-latched pulse width.
module servo_pwm
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned MIN_CYCLES   = 50000,
  parameter int unsigned STEP_CYCLES  = 196
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             pos_valid,
  input  logic [POS_W-1:0] pos_data,
  output logic             pos_ready,
  output logic             pwm_out,
  output logic             frame_start,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_WIDTH =
    CNT_W'(MIN_CYCLES + 32'(POS_CENTER) * STEP_CYCLES);

  logic             step_tick;
  logic             run;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [CNT_W-1:0] width, width_nxt;
  logic [31:0]      width_calc;
  state_t           state, state_nxt;
  logic [POS_W-1:0] cur_pos, cur_pos_nxt;
  logic [POS_W-1:0] target, target_nxt;
  logic [POS_W-1:0] pending, pending_nxt;
  logic             pending_full, pending_full_nxt;
  logic             take;

  edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .step_tick (step_tick)
  );

  assign take = pos_valid & pos_ready;

  always_comb begin
    frame_cnt_nxt    = '0;
    state_nxt        = state;
    width_nxt        = width;
    width_calc       = 32'(MIN_CYCLES) + 32'(cur_pos) * 32'(STEP_CYCLES);
    cur_pos_nxt      = cur_pos;
    target_nxt       = target;
    pending_nxt      = pending;
    pending_full_nxt = pending_full;

    // Counter holds at 0 for the first post-reset cycle so it lines up with frame_start.
    if (run) begin
      frame_cnt_nxt = (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CNT_W'(1);
    end

    case (state)
      PULSE:   if (frame_cnt == width - CNT_W'(1)) state_nxt = GAP;
      GAP:     if (frame_cnt == LAST_CNT)          state_nxt = PULSE;
      default: state_nxt = PULSE;
    endcase

    if (frame_start) begin
      width_nxt = CNT_W'(width_calc);
      if (pending_full) begin
        target_nxt       = pending;
        pending_full_nxt = 1'b0;
      end
    end

    if (take) begin
      pending_nxt      = pos_data;
      pending_full_nxt = 1'b1;
    end

    // Step compares against the pre-update target.
    if (step_tick) begin
      if (cur_pos < target) begin
        cur_pos_nxt = cur_pos + POS_W'(1);
      end else if (cur_pos > target) begin
        cur_pos_nxt = cur_pos - POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run          <= 1'b0;
      frame_cnt    <= '0;
      state        <= PULSE;
      width        <= RESET_WIDTH;
      cur_pos      <= POS_CENTER;
      target       <= POS_CENTER;
      pending      <= '0;
      pending_full <= 1'b0;
      pwm_out      <= 1'b0;
      frame_start  <= 1'b0;
      busy         <= 1'b0;
      pos_ready    <= 1'b0;
    end else begin
      run          <= 1'b1;
      frame_cnt    <= frame_cnt_nxt;
      state        <= state_nxt;
      width        <= width_nxt;
      cur_pos      <= cur_pos_nxt;
      target       <= target_nxt;
      pending      <= pending_nxt;
      pending_full <= pending_full_nxt;
      pwm_out      <= (state_nxt == PULSE);
      frame_start  <= (frame_cnt_nxt == '0);
      busy         <= (cur_pos_nxt != target_nxt);
      pos_ready    <= ~pending_full_nxt;
    end
  end

endmodule

// File: tb/tb_servo_pwm.sv
// Directed self-checking bench for servo_pwm with a 1000-cycle frame.
module tb_servo_pwm;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       pos_valid;
  logic [7:0] pos_data;
  logic       pos_ready;
  logic       pwm_out;
  logic       frame_start;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  servo_pwm #(
    .FRAME_CYCLES (1000),
    .MIN_CYCLES   (50),
    .STEP_CYCLES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .pos_valid   (pos_valid),
    .pos_data    (pos_data),
    .pos_ready   (pos_ready),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sclk(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      step(4);
      sclk = 1'b0;
      step(4);
    end
  endtask

  task automatic wait_fs(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_fs_timeout"}, 0, 1);
  endtask

  task automatic wait_cnt(input string tag, input int cnt);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if (int'(dut.frame_cnt) == cnt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk({tag, "_cnt_timeout"}, 0, 1);
  endtask

  // Starts at a frame_start sample, ends at the next one.
  task automatic measure(output int high, output int period);
    high   = int'(pwm_out);
    period = 1;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (frame_start) break;
      high   += int'(pwm_out);
      period++;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, per, viol;
    rst       = 1'b1;
    sclk      = 1'b0;
    pos_valid = 1'b0;
    pos_data  = 8'd0;
    step(5);

    // Reset state
    chk("rst_pwm",       int'(pwm_out), 0);
    chk("rst_fs",        int'(frame_start), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_ready",     int'(pos_ready), 0);
    chk("rst_cur",       int'(dut.cur_pos), 128);
    chk("rst_target",    int'(dut.target), 128);
    chk("rst_width",     int'(dut.width), 306);
    chk("rst_cnt",       int'(dut.frame_cnt), 0);

    rst = 1'b0;
    step(1);
    chk("rel_fs",    int'(frame_start), 1);
    chk("rel_ready", int'(pos_ready), 1);
    chk("rel_pwm",   int'(pwm_out), 1);

    // Idle frames at center position
    for (int f = 0; f < 3; f++) begin
      measure(hi, per);
      chk("idle_high",   hi, 306);
      chk("idle_period", per, 1000);
      chk("idle_busy",   int'(busy), 0);
    end

    // Mid-frame write of 200, no steps
    step(100);
    pos_valid = 1'b1;
    pos_data  = 8'd200;
    step(1);
    pos_valid = 1'b0;
    chk("w200_ready_low", int'(pos_ready), 0);
    chk("w200_pend_full", int'(dut.pending_full), 1);
    viol = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (frame_start) break;
      if (pos_ready) viol++;
    end
    chk("w200_ready_at_fs", int'(pos_ready), 0);
    chk("w200_ready_early", viol, 0);
    step(1);
    chk("w200_ready_back", int'(pos_ready), 1);
    chk("w200_target",     int'(dut.target), 200);
    chk("w200_busy",       int'(busy), 1);
    chk("w200_width",      int'(dut.width), 306);
    wait_fs("w200");
    measure(hi, per);
    chk("w200_high", hi, 306);
    chk("w200_cur",  int'(dut.cur_pos), 128);

    // 72 steps take cur_pos from 128 to 200
    pulse_sclk(72);
    step(10);
    chk("slew_cur",  int'(dut.cur_pos), 200);
    chk("slew_busy", int'(busy), 0);
    wait_fs("slew");
    measure(hi, per);
    chk("slew_high",   hi, 450);
    chk("slew_period", per, 1000);
    pulse_sclk(10);
    step(5);
    chk("slew_hold_cur",  int'(dut.cur_pos), 200);
    chk("slew_hold_busy", int'(busy), 0);

    // Back-to-back 0 then 255 with pos_valid held
    wait_fs("b2b_sync");
    step(50);
    pos_valid = 1'b1;
    pos_data  = 8'd0;
    step(1);
    chk("b2b_ready_low", int'(pos_ready), 0);
    chk("b2b_pend0",     int'(dut.pending), 0);
    pos_data = 8'd255;
    wait_fs("b2b");
    chk("b2b_pend_at_fs",  int'(dut.pending), 0);
    chk("b2b_ready_at_fs", int'(pos_ready), 0);
    step(1);
    chk("b2b_ready_back", int'(pos_ready), 1);
    chk("b2b_target0",    int'(dut.target), 0);
    chk("b2b_pend_clear", int'(dut.pending_full), 0);
    step(1);
    pos_valid = 1'b0;
    chk("b2b_pend255",    int'(dut.pending), 255);
    chk("b2b_pend_full",  int'(dut.pending_full), 1);
    chk("b2b_ready_low2", int'(pos_ready), 0);
    wait_fs("b2b_final");
    step(1);
    chk("b2b_target255", int'(dut.target), 255);

    // Reset mid-pulse with a value pending
    pos_valid = 1'b1;
    pos_data  = 8'd77;
    step(1);
    pos_valid = 1'b0;
    chk("mrst_pend_full", int'(dut.pending_full), 1);
    wait_cnt("mrst", 100);
    chk("mrst_pwm_before", int'(pwm_out), 1);
    rst = 1'b1;
    step(1);
    chk("mrst_pwm",       int'(pwm_out), 0);
    chk("mrst_pend",      int'(dut.pending_full), 0);
    chk("mrst_cur",       int'(dut.cur_pos), 128);
    chk("mrst_target",    int'(dut.target), 128);
    step(2);
    rst = 1'b0;
    step(1);
    chk("mrst_fs",  int'(frame_start), 1);
    chk("mrst_cnt", int'(dut.frame_cnt), 0);
    chk("mrst_cur_rel", int'(dut.cur_pos), 128);
    measure(hi, per);
    chk("mrst_high",   hi, 306);
    chk("mrst_period", per, 1000);

    // Step tick coinciding with a pending target transfer
    pos_valid = 1'b1;
    pos_data  = 8'd50;
    step(1);
    pos_valid = 1'b0;
    wait_fs("co_t50");
    step(1);
    chk("co_target50", int'(dut.target), 50);
    pulse_sclk(78);
    step(10);
    chk("co_cur50",  int'(dut.cur_pos), 50);
    chk("co_busy0",  int'(busy), 0);
    wait_fs("co_sync");
    step(1);
    pos_valid = 1'b1;
    pos_data  = 8'd10;
    step(1);
    pos_valid = 1'b0;
    chk("co_pend_full", int'(dut.pending_full), 1);
    wait_cnt("co", 997);
    sclk = 1'b1;
    wait_fs("co_fs");
    chk("co_tick_at_fs", int'(dut.step_tick), 1);
    chk("co_cur_at_fs",  int'(dut.cur_pos), 50);
    step(1);
    chk("co_cur_hold",  int'(dut.cur_pos), 50);
    chk("co_target10",  int'(dut.target), 10);
    chk("co_busy1",     int'(busy), 1);
    sclk = 1'b0;
    step(4);
    pulse_sclk(2);
    step(5);
    chk("co_cur_down", int'(dut.cur_pos), 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
